// File: rtl/tlk2711_pkg.sv
// tlk2711_pkg: shared FSM state type and AXI response codes for the TLK2711 register bridge
package tlk2711_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        WR_RESP,
        RD_ISSUE,
        RD_WAIT,
        RD_RESP
    } reg_br_state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/tlk2711_axil_reg_bridge.sv
// tlk2711_axil_reg_bridge: AXI4-Lite slave that serializes PS accesses onto the TLK2711 register strobe bus
//   ps_clk/ps_rst      : clock, synchronous active-high reset
//   s_axil_aw*/w*/b*   : AXI-Lite write channels (64-bit data, 8 strobes)
//   s_axil_ar*/r*      : AXI-Lite read channels
//   o_reg_wen/waddr/wdata : one-cycle register write strobe
//   o_reg_ren/raddr       : one-cycle register read strobe
//   i_reg_rdata           : read data, valid RD_LATENCY cycles after o_reg_ren
module tlk2711_axil_reg_bridge
    import tlk2711_pkg::*;
#(
    parameter int ADDR_LSB       = 0,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int RD_LATENCY     = 1
) (
    input  logic                      ps_clk,
    input  logic                      ps_rst,
    input  logic                      s_axil_awvalid,
    output logic                      s_axil_awready,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic                      s_axil_wvalid,
    output logic                      s_axil_wready,
    input  logic [63:0]               s_axil_wdata,
    input  logic [7:0]                s_axil_wstrb,
    output logic                      s_axil_bvalid,
    input  logic                      s_axil_bready,
    output logic [1:0]                s_axil_bresp,
    input  logic                      s_axil_arvalid,
    output logic                      s_axil_arready,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axil_araddr,
    output logic                      s_axil_rvalid,
    input  logic                      s_axil_rready,
    output logic [63:0]               s_axil_rdata,
    output logic [1:0]                s_axil_rresp,
    output logic                      o_reg_wen,
    output logic [15:0]               o_reg_waddr,
    output logic [63:0]               o_reg_wdata,
    output logic                      o_reg_ren,
    output logic [15:0]               o_reg_raddr,
    input  logic [63:0]               i_reg_rdata
);

    localparam logic [2:0] CNT_INIT = 3'(RD_LATENCY - 1);

    reg_br_state_t state_q, state_d;

    logic        aw_full_q, w_full_q, ar_full_q, w_strb_ff_q, wr_full_q, last_wr_q;
    logic [15:0] aw_addr_q, ar_addr_q, waddr_q, raddr_q;
    logic [63:0] w_data_q, wdata_q, rdata_q;
    logic [1:0]  bresp_q;
    logic [2:0]  cnt_q;

    logic        idle, aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic        wr_elig, rd_elig, go_wr, go_rd, strb_ff;
    logic [15:0] aw_addr, ar_addr;
    logic        unused_addr_bits;

    assign aw_addr = s_axil_awaddr[ADDR_LSB +: 16];
    assign ar_addr = s_axil_araddr[ADDR_LSB +: 16];
    assign unused_addr_bits = ^{s_axil_awaddr, s_axil_araddr};

    // Gating with ps_rst keeps every handshake and strobe quiet in the reset cycle itself.
    assign idle           = state_q == IDLE && !ps_rst;
    assign s_axil_awready = idle && !aw_full_q;
    assign s_axil_wready  = idle && !w_full_q;
    assign s_axil_arready = idle && !ar_full_q;

    assign aw_hs = s_axil_awvalid && s_axil_awready;
    assign w_hs  = s_axil_wvalid && s_axil_wready;
    assign ar_hs = s_axil_arvalid && s_axil_arready;
    assign b_hs  = s_axil_bvalid && s_axil_bready;
    assign r_hs  = s_axil_rvalid && s_axil_rready;

    // Eligibility looks through to same-cycle handshakes so the issue cycle follows the last handshake directly.
    assign wr_elig = (aw_full_q || aw_hs) && (w_full_q || w_hs);
    assign rd_elig = ar_full_q || ar_hs;
    assign go_wr   = idle && wr_elig && (!rd_elig || !last_wr_q);
    assign go_rd   = idle && rd_elig && !go_wr;
    assign strb_ff = w_hs ? &s_axil_wstrb : w_strb_ff_q;

    assign s_axil_bresp = bresp_q;
    assign s_axil_rdata = rdata_q;
    assign s_axil_rresp = AXI_RESP_OKAY;
    assign o_reg_waddr  = waddr_q;
    assign o_reg_wdata  = wdata_q;
    assign o_reg_raddr  = raddr_q;

    always_ff @(posedge ps_clk) begin
        if (ps_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        o_reg_wen     = 1'b0;
        o_reg_ren     = 1'b0;
        s_axil_bvalid = 1'b0;
        s_axil_rvalid = 1'b0;
        case (state_q)
            IDLE:     state_d = go_wr ? WR_ISSUE : go_rd ? RD_ISSUE : IDLE;
            WR_ISSUE: begin
                state_d   = WR_RESP;
                o_reg_wen = wr_full_q && !ps_rst;
            end
            WR_RESP:  begin
                state_d       = s_axil_bready ? IDLE : WR_RESP;
                s_axil_bvalid = !ps_rst;
            end
            RD_ISSUE: begin
                state_d   = RD_WAIT;
                o_reg_ren = !ps_rst;
            end
            RD_WAIT:  state_d = cnt_q == 3'd0 ? RD_RESP : RD_WAIT;
            RD_RESP:  begin
                state_d       = s_axil_rready ? IDLE : RD_RESP;
                s_axil_rvalid = !ps_rst;
            end
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge ps_clk) begin
        if (ps_rst) begin
            aw_full_q   <= 1'b0;
            w_full_q    <= 1'b0;
            ar_full_q   <= 1'b0;
            w_strb_ff_q <= 1'b0;
            wr_full_q   <= 1'b0;
            last_wr_q   <= 1'b0;
            aw_addr_q   <= '0;
            ar_addr_q   <= '0;
            w_data_q    <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            raddr_q     <= '0;
            rdata_q     <= '0;
            bresp_q     <= AXI_RESP_OKAY;
            cnt_q       <= '0;
        end else begin
            if (aw_hs) begin
                aw_full_q <= 1'b1;
                aw_addr_q <= aw_addr;
            end
            if (w_hs) begin
                w_full_q    <= 1'b1;
                w_data_q    <= s_axil_wdata;
                w_strb_ff_q <= &s_axil_wstrb;
            end
            if (ar_hs) begin
                ar_full_q <= 1'b1;
                ar_addr_q <= ar_addr;
            end
            if (b_hs) begin
                aw_full_q <= 1'b0;
                w_full_q  <= 1'b0;
            end
            if (r_hs) begin
                ar_full_q <= 1'b0;
            end
            // Bus-side outputs load only at arbitration so they stay frozen outside the transaction window.
            if (go_wr) begin
                last_wr_q <= 1'b1;
                waddr_q   <= aw_hs ? aw_addr : aw_addr_q;
                wdata_q   <= w_hs ? s_axil_wdata : w_data_q;
                wr_full_q <= strb_ff;
                bresp_q   <= strb_ff ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            end
            if (go_rd) begin
                last_wr_q <= 1'b0;
                raddr_q   <= ar_hs ? ar_addr : ar_addr_q;
            end
            if (state_q == RD_ISSUE) begin
                cnt_q <= CNT_INIT;
            end else if (state_q == RD_WAIT) begin
                cnt_q <= cnt_q - 3'd1;
            end
            if (state_q == RD_WAIT && cnt_q == 3'd0) begin
                rdata_q <= i_reg_rdata;
            end
        end
    end

endmodule

// File: tb/tb_tlk2711_axil_reg_bridge.sv
// tb_tlk2711_axil_reg_bridge: directed and back-pressure checks of the AXI-Lite register bridge
module tb_tlk2711_axil_reg_bridge;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_axil_awvalid, s_axil_awready, s_axil_wvalid, s_axil_wready;
    logic        s_axil_bvalid, s_axil_bready, s_axil_arvalid, s_axil_arready;
    logic        s_axil_rvalid, s_axil_rready, o_reg_wen, o_reg_ren;
    logic [31:0] s_axil_awaddr, s_axil_araddr;
    logic [63:0] s_axil_wdata, s_axil_rdata, o_reg_wdata, i_reg_rdata;
    logic [7:0]  s_axil_wstrb;
    logic [1:0]  s_axil_bresp, s_axil_rresp;
    logic [15:0] o_reg_waddr, o_reg_raddr;

    logic b_fix = 1'b1, r_fix = 1'b1, rnd_bp = 1'b0, rnd_b = 1'b0, rnd_r = 1'b0;

    always #5 clk = ~clk;

    assign s_axil_bready = rnd_bp ? rnd_b : b_fix;
    assign s_axil_rready = rnd_bp ? rnd_r : r_fix;

    always @(negedge clk) begin
        rnd_b = 1'($urandom_range(0, 1));
        rnd_r = 1'($urandom_range(0, 1));
    end

    tlk2711_axil_reg_bridge #(
        .ADDR_LSB       (0),
        .AXI_ADDR_WIDTH (32),
        .RD_LATENCY     (LAT)
    ) dut (
        .ps_clk         (clk),
        .ps_rst         (rst),
        .s_axil_awvalid (s_axil_awvalid),
        .s_axil_awready (s_axil_awready),
        .s_axil_awaddr  (s_axil_awaddr),
        .s_axil_wvalid  (s_axil_wvalid),
        .s_axil_wready  (s_axil_wready),
        .s_axil_wdata   (s_axil_wdata),
        .s_axil_wstrb   (s_axil_wstrb),
        .s_axil_bvalid  (s_axil_bvalid),
        .s_axil_bready  (s_axil_bready),
        .s_axil_bresp   (s_axil_bresp),
        .s_axil_arvalid (s_axil_arvalid),
        .s_axil_arready (s_axil_arready),
        .s_axil_araddr  (s_axil_araddr),
        .s_axil_rvalid  (s_axil_rvalid),
        .s_axil_rready  (s_axil_rready),
        .s_axil_rdata   (s_axil_rdata),
        .s_axil_rresp   (s_axil_rresp),
        .o_reg_wen      (o_reg_wen),
        .o_reg_waddr    (o_reg_waddr),
        .o_reg_wdata    (o_reg_wdata),
        .o_reg_ren      (o_reg_ren),
        .o_reg_raddr    (o_reg_raddr),
        .i_reg_rdata    (i_reg_rdata)
    );

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rd_model(input logic [15:0] a);
        return a == 16'h0020 ? 64'hDEADBEEF00000001 : {a, ~a, a ^ 16'h5A5A, 16'h1234};
    endfunction

    // Register manager model: answers a read strobe LAT cycles later.
    logic [LAT-1:0] pv = '0;
    logic [15:0]    pa [LAT];

    always @(posedge clk) begin
        pv    <= {pv[LAT-2:0], o_reg_ren};
        pa[0] <= o_reg_raddr;
        for (int i = 1; i < LAT; i++) pa[i] <= pa[i-1];
    end

    assign i_reg_rdata = pv[LAT-1] ? rd_model(pa[LAT-1]) : 64'hBAD0BAD0BAD0BAD0;

    // Bus monitor: counts handshakes and strobes, records their cycle and payload.
    int          cyc = 0, n_aw = 0, n_w = 0, n_ar = 0, n_b = 0, n_r = 0, n_wen = 0, n_ren = 0;
    int          c_aw = 0, c_w = 0, c_ar = 0, c_b = 0, c_r = 0, c_wen = 0, c_ren = 0;
    logic [15:0] m_waddr = '0, m_raddr = '0;
    logic [63:0] m_wdata = '0, m_rdata = '0;
    logic [1:0]  m_bresp = '0, m_rresp = '0;
    int          ord[$];

    always @(posedge clk) begin
        if (s_axil_awvalid && s_axil_awready) begin n_aw++; c_aw = cyc; end
        if (s_axil_wvalid && s_axil_wready) begin n_w++; c_w = cyc; end
        if (s_axil_arvalid && s_axil_arready) begin n_ar++; c_ar = cyc; end
        if (s_axil_bvalid && s_axil_bready) begin n_b++; c_b = cyc; m_bresp = s_axil_bresp; end
        if (s_axil_rvalid && s_axil_rready) begin
            n_r++; c_r = cyc; m_rdata = s_axil_rdata; m_rresp = s_axil_rresp;
        end
        if (o_reg_wen) begin
            n_wen++; c_wen = cyc; m_waddr = o_reg_waddr; m_wdata = o_reg_wdata; ord.push_back(1);
        end
        if (o_reg_ren) begin
            n_ren++; c_ren = cyc; m_raddr = o_reg_raddr; ord.push_back(2);
        end
        if (o_reg_wen || o_reg_ren) chk("strobe_overlap", 64'(o_reg_wen & o_reg_ren), 64'd0);
        cyc++;
    end

    function automatic int cnt_of(input int k);
        return k == 0 ? n_aw : k == 1 ? n_w : k == 2 ? n_ar : k == 3 ? n_b : n_r;
    endfunction

    task automatic wait_evt(input string tag, input int k, input int n0);
        for (int i = 0; i < 60 && cnt_of(k) == n0; i++) @(negedge clk);
        chk({tag, "_event"}, 64'(cnt_of(k)), 64'(n0 + 1));
    endtask

    task automatic put_aw(input logic [15:0] a);
        int n0 = n_aw;
        s_axil_awaddr  = {16'h0, a};
        s_axil_awvalid = 1'b1;
        wait_evt("aw", 0, n0);
        s_axil_awvalid = 1'b0;
    endtask

    task automatic put_w(input logic [63:0] d, input logic [7:0] s);
        int n0 = n_w;
        s_axil_wdata  = d;
        s_axil_wstrb  = s;
        s_axil_wvalid = 1'b1;
        wait_evt("w", 1, n0);
        s_axil_wvalid = 1'b0;
    endtask

    task automatic put_ar(input logic [15:0] a);
        int n0 = n_ar;
        s_axil_araddr  = {16'h0, a};
        s_axil_arvalid = 1'b1;
        wait_evt("ar", 2, n0);
        s_axil_arvalid = 1'b0;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [63:0] d, input logic [7:0] s, input string tag);
        int nb0 = n_b, nw0 = n_wen;
        fork
            put_aw(a);
            put_w(d, s);
        join
        wait_evt({tag, "_b"}, 3, nb0);
        chk({tag, "_wen_cnt"}, 64'(n_wen - nw0), 64'(s == 8'hFF));
        if (s == 8'hFF) begin
            chk({tag, "_waddr"}, 64'(m_waddr), 64'(a));
            chk({tag, "_wdata"}, m_wdata, d);
        end
        chk({tag, "_bresp"}, 64'(m_bresp), s == 8'hFF ? 64'd0 : 64'd2);
    endtask

    task automatic do_read(input logic [15:0] a, input string tag);
        int nr0 = n_r, nren0 = n_ren;
        put_ar(a);
        wait_evt({tag, "_r"}, 4, nr0);
        chk({tag, "_ren_cnt"}, 64'(n_ren - nren0), 64'd1);
        chk({tag, "_raddr"}, 64'(m_raddr), 64'(a));
        chk({tag, "_rdata"}, m_rdata, rd_model(a));
        chk({tag, "_rresp"}, 64'(m_rresp), 64'd0);
    endtask

    task automatic tie_round(input logic [15:0] a, input int first, input string tag);
        int nb0 = n_b, nr0 = n_r;
        ord.delete();
        fork
            put_aw(a);
            put_w({48'h0, a}, 8'hFF);
            put_ar(a + 16'h0100);
        join
        wait_evt({tag, "_b"}, 3, nb0);
        wait_evt({tag, "_r"}, 4, nr0);
        chk({tag, "_n"}, 64'(ord.size()), 64'd2);
        chk({tag, "_first"}, 64'(ord[0]), 64'(first));
        chk({tag, "_second"}, 64'(ord[1]), 64'(3 - first));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int fv;
        int nb0, nw0, nr0;
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        s_axil_arvalid = 1'b0;
        s_axil_awaddr  = '0;
        s_axil_araddr  = '0;
        s_axil_wdata   = '0;
        s_axil_wstrb   = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'({s_axil_awready, s_axil_wready, s_axil_arready}), 64'd0);
        chk("rst_valid_strobe", 64'({s_axil_bvalid, s_axil_rvalid, o_reg_wen, o_reg_ren}), 64'd0);
        chk("rst_resp", 64'({s_axil_bresp, s_axil_rresp}), 64'd0);
        chk("rst_rdata", s_axil_rdata, 64'd0);
        chk("rst_waddr_raddr", 64'({o_reg_waddr, o_reg_raddr}), 64'd0);
        chk("rst_wdata", o_reg_wdata, 64'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 64'({s_axil_awready, s_axil_wready, s_axil_arready}), 64'h7);

        // Write with AW and W in the same cycle.
        @(negedge clk);
        do_write(16'h0010, 64'h1122334455667788, 8'hFF, "t1");
        chk("t1_same_cycle", 64'(c_w), 64'(c_aw));
        chk("t1_wen_cyc", 64'(c_wen), 64'(c_aw + 1));
        chk("t1_b_cyc", 64'(c_b), 64'(c_aw + 2));

        // W two cycles ahead of AW, partial strobe, B held off.
        b_fix = 1'b0;
        nb0 = n_b;
        nw0 = n_wen;
        fork
            put_w(64'hCAFEF00DCAFEF00D, 8'h0F);
            begin
                repeat (2) @(negedge clk);
                put_aw(16'h0030);
            end
        join
        chk("t2_w_lead", 64'(c_aw - c_w), 64'd2);
        chk("t2_no_wen_issue", 64'(o_reg_wen), 64'd0);
        repeat (3) @(negedge clk);
        chk("t2_bvalid_held", 64'(s_axil_bvalid), 64'd1);
        chk("t2_bresp_live", 64'(s_axil_bresp), 64'd2);
        chk("t2_ready_low", 64'({s_axil_awready, s_axil_wready}), 64'd0);
        b_fix = 1'b1;
        wait_evt("t2_b", 3, nb0);
        chk("t2_wen_cnt", 64'(n_wen - nw0), 64'd0);
        chk("t2_bresp", 64'(m_bresp), 64'd2);
        chk("t2_ready_back", 64'({s_axil_awready, s_axil_wready}), 64'd3);

        // Read with latency 3 and R held off for 4 cycles.
        r_fix = 1'b0;
        nr0 = n_r;
        put_ar(16'h0020);
        fv = -1;
        for (int i = 0; i < 20; i++) begin
            if (s_axil_rvalid) begin
                fv = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("t3_ren_cyc", 64'(c_ren), 64'(c_ar + 1));
        chk("t3_raddr", 64'(m_raddr), 64'h20);
        chk("t3_rvalid_cyc", 64'(fv), 64'(c_ar + 5));
        for (int i = 0; i < 4; i++) begin
            chk("t3_rvalid_stall", 64'(s_axil_rvalid), 64'd1);
            chk("t3_rdata_stall", s_axil_rdata, 64'hDEADBEEF00000001);
            @(negedge clk);
        end
        r_fix = 1'b1;
        wait_evt("t3_r", 4, nr0);
        chk("t3_rdata", m_rdata, 64'hDEADBEEF00000001);
        chk("t3_rresp", 64'(m_rresp), 64'd0);

        // Round-robin: read served last, so write first; after a lone write, read first.
        tie_round(16'h0044, 1, "t4a");
        do_write(16'h0048, 64'h0123456789ABCDEF, 8'hFF, "t4w");
        tie_round(16'h004C, 2, "t4b");

        // Reset pulsed while the read is waiting for data.
        nr0 = n_r;
        put_ar(16'h0040);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5_rst_ready", 64'({s_axil_awready, s_axil_wready, s_axil_arready}), 64'd0);
        chk("t5_rst_strobe", 64'({s_axil_rvalid, o_reg_ren, o_reg_wen}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_addr_cleared", 64'({o_reg_waddr, o_reg_raddr}), 64'd0);
        chk("t5_wdata_cleared", o_reg_wdata, 64'd0);
        chk("t5_rdata_cleared", s_axil_rdata, 64'd0);
        chk("t5_valid_cleared", 64'({s_axil_bvalid, s_axil_rvalid, s_axil_bresp}), 64'd0);
        chk("t5_ready_back", 64'({s_axil_awready, s_axil_wready, s_axil_arready}), 64'h7);
        repeat (10) @(negedge clk);
        chk("t5_no_rvalid", 64'(n_r), 64'(nr0));
        do_read(16'h0020, "t5r");

        // Mixed traffic under random B/R back-pressure.
        rnd_bp = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 1) == 1)
                do_write(16'($urandom), {$urandom, $urandom},
                         $urandom_range(0, 3) == 0 ? 8'($urandom) : 8'hFF, "t6w");
            else
                do_read(16'($urandom), "t6r");
        end
        rnd_bp = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
